// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: instruction memory port, redirect and decode handoff
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall_d;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;

    modport master (
        output imem_req, imem_addr, valid_d, instr_d, pc_d, pcplus4_d,
        input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, stall_d
    );

    modport slave (
        input  imem_req, imem_addr, valid_d, instr_d, pc_d, pcplus4_d,
        output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, stall_d
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with 2-entry in-order buffer and redirect flush
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc_q;
    logic [1:0]  r_outstanding;
    logic [1:0]  r_count;
    logic [1:0]  r_drop;
    logic [31:0] r_buf_pc    [2];
    logic [31:0] r_buf_instr [2];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [31:0] r_pc_hold;

    logic        w_req;
    logic        w_accept;
    logic        w_resp;
    logic        w_write;
    logic        w_valid;
    logic        w_consume;
    logic [2:0]  w_inflight;
    logic [1:0]  w_out_dec;
    logic [31:0] w_resp_pc;
    logic [31:0] w_pc_d;

    // Request gating, response bookkeeping and decode-side view of the buffer head
    always_comb begin
        w_inflight = {1'b0, r_outstanding} + {1'b0, r_count};
        w_req      = rst_n && (r_state == ST_FETCH) && (w_inflight < 3'd2) && !bus.redirect;
        w_accept   = w_req && bus.imem_ready;
        // Responses with nothing outstanding (stale traffic across reset) are ignored
        w_resp     = bus.imem_rvalid && (r_outstanding != 2'd0);
        w_out_dec  = r_outstanding - {1'b0, w_resp};
        w_write    = w_resp && (r_state == ST_FETCH) && !bus.redirect;
        w_valid    = (r_count != 2'd0);
        w_consume  = w_valid && !bus.stall_d && !bus.redirect;
        // In FETCH every outstanding request is sequential behind pc_q, so the
        // oldest one (the one now answering) sits outstanding words back
        w_resp_pc  = r_pc_q - {28'd0, r_outstanding, 2'b00};
        w_pc_d     = w_valid ? r_buf_pc[r_rd_ptr] : r_pc_hold;
    end

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = r_pc_q;
    assign bus.valid_d   = w_valid;
    assign bus.instr_d   = w_valid ? r_buf_instr[r_rd_ptr] : NOP_INSTR;
    assign bus.pc_d      = w_pc_d;
    assign bus.pcplus4_d = w_pc_d + 32'd4;

    // FETCH/FLUSH state machine with pc, counters and instruction buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_FETCH;
            r_pc_q        <= RESET_PC;
            r_outstanding <= 2'd0;
            r_count       <= 2'd0;
            r_drop        <= 2'd0;
            r_rd_ptr      <= 1'b0;
            r_wr_ptr      <= 1'b0;
            r_pc_hold     <= RESET_PC;
            for (int i = 0; i < 2; i++) begin
                r_buf_pc[i]    <= '0;
                r_buf_instr[i] <= '0;
            end
        end else begin
            if (w_valid) begin
                r_pc_hold <= r_buf_pc[r_rd_ptr];
            end
            if (bus.redirect) begin
                // Everything still in flight belongs to the wrong path
                r_pc_q        <= bus.redirect_pc & ~32'd3;
                r_outstanding <= w_out_dec;
                r_drop        <= w_out_dec;
                r_count       <= 2'd0;
                r_rd_ptr      <= 1'b0;
                r_wr_ptr      <= 1'b0;
                r_state       <= (w_out_dec != 2'd0) ? ST_FLUSH : ST_FETCH;
            end else begin
                case (r_state)
                    ST_FETCH: begin
                        if (w_accept) begin
                            r_pc_q <= r_pc_q + 32'd4;
                        end
                        r_outstanding <= r_outstanding + {1'b0, w_accept} - {1'b0, w_resp};
                        if (w_write) begin
                            r_buf_pc[r_wr_ptr]    <= w_resp_pc;
                            r_buf_instr[r_wr_ptr] <= bus.imem_rdata;
                            r_wr_ptr              <= ~r_wr_ptr;
                        end
                        if (w_consume) begin
                            r_rd_ptr <= ~r_rd_ptr;
                        end
                        r_count <= r_count + {1'b0, w_write} - {1'b0, w_consume};
                    end
                    ST_FLUSH: begin
                        r_outstanding <= w_out_dec;
                        if (w_resp) begin
                            r_drop <= r_drop - 2'd1;
                            if (r_drop == 2'd1) begin
                                r_state <= ST_FETCH;
                            end
                        end
                    end
                    default: r_state <= ST_FETCH;
                endcase
            end
        end
    end

`ifndef SYNTHESIS
    // A live response with the buffer already full means the request gating broke
    assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.imem_rvalid && (r_state == ST_FETCH) && (r_outstanding != 2'd0) && (r_count == 2'd2)));
    assert property (@(posedge clk) disable iff (!rst_n)
        (({1'b0, r_outstanding} + {1'b0, r_count}) <= 3'd2));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with memory model and pc-stream scoreboard
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk;
    logic rst_n;
    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mq_addr[$];
    int          mq_due[$];
    logic [31:0] cons_q[$];
    logic [31:0] p4_q[$];
    int          cyc, first_valid, n_cons, stale, lat_min, lat_max;
    logic [31:0] next_fetch, exp_pc, redir_pc, prev_pc, prev_instr;
    logic        redir_now, stall, hold_resp, rand_ready, inject_stale, after_redir, hold_prev;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr, s_p4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic model_reset();
        mq_addr.delete();
        mq_due.delete();
        stale = 0;
        next_fetch = RESET_PC;
        exp_pc = RESET_PC;
        after_redir = 1'b0;
        hold_prev = 1'b0;
        first_valid = -1;
        cyc = 0;
    endtask

    task automatic tick();
        logic rv, acc;
        rv = 1'b0;
        if (inject_stale) rv = 1'b1;
        else if (mq_addr.size() != 0 && !hold_resp) rv = (mq_due[0] <= cyc);
        bus.imem_rvalid = rv;
        if (rv && !inject_stale) bus.imem_rdata = mem_word(mq_addr[0]);
        else bus.imem_rdata = $urandom();
        bus.imem_ready  = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        bus.redirect    = redir_now;
        bus.redirect_pc = redir_pc;
        bus.stall_d     = stall;
        #1;
        s_req = bus.imem_req; s_addr = bus.imem_addr; s_valid = bus.valid_d;
        s_pc = bus.pc_d; s_instr = bus.instr_d; s_p4 = bus.pcplus4_d;

        n_checks++;
        if (s_addr !== next_fetch || s_addr[1:0] !== 2'b00) begin
            n_errors++; $display("FAIL imem_addr cyc=%0d got %h exp %h", cyc, s_addr, next_fetch);
        end
        if (stale > 0 || redir_now) begin
            n_checks++;
            if (s_req !== 1'b0) begin
                n_errors++; $display("FAIL req_blocked cyc=%0d got %b exp 0 (stale=%0d)", cyc, s_req, stale);
            end
        end
        if (after_redir) begin
            n_checks++;
            if (s_valid !== 1'b0) begin
                n_errors++; $display("FAIL empty_after_redirect cyc=%0d got valid %b exp 0", cyc, s_valid);
            end
        end
        if (hold_prev) begin
            n_checks++;
            if (s_valid !== 1'b1 || s_pc !== prev_pc || s_instr !== prev_instr) begin
                n_errors++; $display("FAIL stall_hold cyc=%0d got v=%b pc=%h exp v=1 pc=%h", cyc, s_valid, s_pc, prev_pc);
            end
        end
        if (s_valid !== 1'b1) begin
            n_checks++;
            if (s_instr !== NOP) begin
                n_errors++; $display("FAIL nop_when_empty cyc=%0d got %h exp %h", cyc, s_instr, NOP);
            end
        end
        if (s_valid === 1'b1 && first_valid < 0) first_valid = cyc;
        if (s_valid === 1'b1 && !stall && !redir_now) begin
            n_checks++;
            if (s_pc !== exp_pc || s_instr !== mem_word(exp_pc) || s_p4 !== exp_pc + 32'd4) begin
                n_errors++;
                $display("FAIL consume cyc=%0d got pc=%h instr=%h p4=%h exp pc=%h instr=%h p4=%h",
                         cyc, s_pc, s_instr, s_p4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
            end
            cons_q.push_back(s_pc);
            p4_q.push_back(s_p4);
            n_cons++;
            exp_pc = exp_pc + 32'd4;
        end

        acc = s_req && bus.imem_ready;
        if (rv && !inject_stale) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
            if (stale > 0) stale--;
        end
        if (acc) begin
            mq_addr.push_back(next_fetch);
            mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
            next_fetch = next_fetch + 32'd4;
        end
        if (redir_now) begin
            next_fetch = redir_pc & ~32'd3;
            exp_pc = next_fetch;
            stale = mq_addr.size();
        end
        n_checks++;
        if (mq_addr.size() > 2) begin
            n_errors++; $display("FAIL outstanding_bound cyc=%0d got %0d exp <=2", cyc, mq_addr.size());
        end
        after_redir = redir_now;
        hold_prev = (s_valid === 1'b1) && stall && !redir_now;
        prev_pc = s_pc;
        prev_instr = s_instr;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        rand_ready = 1'b0; lat_min = 1; lat_max = 1;
        stall = 1'b0; redir_now = 1'b0; hold_resp = 1'b0;
        bus.redirect = 1'b0; bus.stall_d = 1'b0; bus.imem_ready = 1'b1;
        bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0; bus.redirect_pc = '0;
        #1;
        n_checks++;
        if (bus.valid_d !== 1'b0 || bus.instr_d !== NOP || bus.imem_req !== 1'b0) begin
            n_errors++; $display("FAIL reset_outputs got v=%b instr=%h req=%b exp v=0 instr=%h req=0",
                                 bus.valid_d, bus.instr_d, bus.imem_req, NOP);
        end
        n_checks++;
        if (bus.pc_d !== RESET_PC || bus.pcplus4_d !== RESET_PC + 32'd4 || bus.imem_addr !== RESET_PC) begin
            n_errors++; $display("FAIL reset_pcs got pc=%h p4=%h addr=%h exp %h %h %h",
                                 bus.pc_d, bus.pcplus4_d, bus.imem_addr, RESET_PC, RESET_PC + 32'd4, RESET_PC);
        end
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        inject_stale = 1'b1;
        tick();
        inject_stale = 1'b0;
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== RESET_PC) begin
            n_errors++; $display("FAIL first_request got req=%b addr=%h exp req=1 addr=%h", s_req, s_addr, RESET_PC);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        cons_q.delete();
        repeat (3) tick();
        n_checks++;
        if (first_valid != 2) begin
            n_errors++; $display("FAIL first_valid_cycle got %0d exp 2", first_valid);
        end
        n_checks++;
        if (cons_q.size() < 2 || cons_q[0] !== 32'h0 || cons_q[1] !== 32'h4) begin
            n_errors++; $display("FAIL initial_stream got n=%0d exp pcs 0,4", cons_q.size());
        end
    endtask

    task automatic test_stall();
        logic [31:0] e;
        int c0;
        stall = 1'b1;
        repeat (6) tick();
        repeat (5) begin
            tick();
            n_checks++;
            if (s_req !== 1'b0 || s_valid !== 1'b1 || s_pc !== exp_pc) begin
                n_errors++; $display("FAIL stall_full got req=%b v=%b pc=%h exp req=0 v=1 pc=%h", s_req, s_valid, s_pc, exp_pc);
            end
        end
        e = exp_pc;
        stall = 1'b0;
        c0 = n_cons;
        cons_q.delete();
        tick();
        tick();
        n_checks++;
        if (n_cons != c0 + 2 || cons_q.size() != 2 || cons_q[0] !== e || cons_q[1] !== e + 32'd4) begin
            n_errors++; $display("FAIL stall_release got %0d consumed exp 2 starting at %h", n_cons - c0, e);
        end
    endtask

    task automatic test_redirect_flush();
        int guard = 0;
        lat_min = 3; lat_max = 3;
        while (mq_addr.size() != 2 && guard < 50) begin tick(); guard++; end
        n_checks++;
        if (mq_addr.size() != 2) begin
            n_errors++; $display("FAIL flush_setup got outstanding %0d exp 2", mq_addr.size());
        end
        hold_resp = 1'b1; redir_now = 1'b1; redir_pc = 32'h0000_0102;
        tick();
        hold_resp = 1'b0; redir_now = 1'b0;
        cons_q.delete();
        tick();
        n_checks++;
        if (s_valid !== 1'b0 || s_addr !== 32'h0000_0100) begin
            n_errors++; $display("FAIL flush_next got v=%b addr=%h exp v=0 addr=00000100", s_valid, s_addr);
        end
        repeat (15) tick();
        n_checks++;
        if (cons_q.size() == 0 || cons_q[0] !== 32'h0000_0100) begin
            n_errors++; $display("FAIL flush_target got n=%0d exp first pc 00000100", cons_q.size());
        end
    endtask

    task automatic test_redirect_rvalid();
        int guard = 0;
        lat_min = 1; lat_max = 1;
        while (!(mq_addr.size() == 1 && mq_due[0] <= cyc) && guard < 50) begin tick(); guard++; end
        redir_now = 1'b1; redir_pc = 32'h0000_4000;
        tick();
        redir_now = 1'b0;
        cons_q.delete();
        tick();
        n_checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_4000) begin
            n_errors++; $display("FAIL redirect_rvalid got req=%b addr=%h exp req=1 addr=00004000", s_req, s_addr);
        end
        repeat (6) tick();
        n_checks++;
        if (cons_q.size() == 0 || cons_q[0] !== 32'h0000_4000) begin
            n_errors++; $display("FAIL redirect_rvalid_stream got n=%0d exp first pc 00004000", cons_q.size());
        end
    endtask

    task automatic test_wrap();
        redir_now = 1'b1; redir_pc = 32'hFFFF_FFFE;
        tick();
        redir_now = 1'b0;
        cons_q.delete(); p4_q.delete();
        repeat (12) tick();
        n_checks++;
        if (cons_q.size() < 2 || cons_q[0] !== 32'hFFFF_FFFC || p4_q[0] !== 32'h0 || cons_q[1] !== 32'h0) begin
            n_errors++; $display("FAIL pc_wrap got n=%0d exp pcs FFFFFFFC,0 with pcplus4 0", cons_q.size());
        end
    endtask

    task automatic test_reset_mid();
        lat_min = 2; lat_max = 2;
        stall = 1'b1;
        repeat (8) tick();
        n_checks++;
        if (s_valid !== 1'b1) begin
            n_errors++; $display("FAIL reset_mid_setup got v=%b exp 1", s_valid);
        end
        stall = 1'b0;
        apply_reset();
        cons_q.delete();
        repeat (10) tick();
        n_checks++;
        if (cons_q.size() == 0 || cons_q[0] !== RESET_PC) begin
            n_errors++; $display("FAIL reset_mid_restart got n=%0d exp first pc %h", cons_q.size(), RESET_PC);
        end
    endtask

    task automatic test_random();
        int c0;
        c0 = n_cons;
        rand_ready = 1'b1; lat_min = 1; lat_max = 4;
        for (int i = 0; i < 1500; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            redir_now = ($urandom_range(0, 39) == 0);
            redir_pc = $urandom();
            tick();
        end
        redir_now = 1'b0; stall = 1'b0;
        n_checks++;
        if (n_cons - c0 < 100) begin
            n_errors++; $display("FAIL random_progress got %0d consumed exp >=100", n_cons - c0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        n_cons = 0; cyc = 0;
        redir_now = 1'b0; redir_pc = '0; stall = 1'b0; hold_resp = 1'b0;
        rand_ready = 1'b0; inject_stale = 1'b0; lat_min = 1; lat_max = 1;
        model_reset();
        bus.imem_ready = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
        bus.redirect = 1'b0; bus.redirect_pc = '0; bus.stall_d = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_stall();
        test_redirect_flush();
        test_redirect_rvalid();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
